target_select_tx: RTL

Parametrised successor to the single-byte switch-to-target encoder. It samples the board selection switches, synchronises and debounces them, and encodes the stable value into an 8-bit target frame. Each new committed selection is emitted once as a frame over a valid/ready handshake to the downstream UART/transmit stage. An explicit resend request re-emits the current frame. A held copy of the frame stays available for status LEDs.

---
 rtl/target_frame_pkg.sv | 37 +++
 rtl/switch_debouncer.sv | 98 +++++++++
 rtl/target_select_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/target_frame_pkg.sv
// -----------------------------------------------------------------------------
// target_frame_pkg
// Shared definitions for the target-select transmit path: the frame width,
// the select flag bits, the idle frame, the debounce FSM state type and the
// id-to-frame encoder.
// -----------------------------------------------------------------------------
package target_frame_pkg;

    localparam int FRAME_W = 8;
    localparam logic [1:0] FLAG_SELECT = 2'b11;
    localparam logic [FRAME_W-1:0] FRAME_IDLE = 8'h00;

    typedef enum logic [1:0] {
        DB_CAPTURE = 2'd0,
        DB_COUNT   = 2'd1,
        DB_STABLE  = 2'd2
    } db_state_e;

    // Valid ids become {0, id, 11}; anything outside [id_min, id_max]
    // collapses to the idle frame.
    function automatic logic [FRAME_W-1:0] encode_frame(
        input logic [4:0] id,
        input int         id_min,
        input int         id_max
    );
        logic [FRAME_W-1:0] frame_v;
        int                 id_v;
        id_v = int'({27'd0, id});
        if ((id_v >= id_min) && (id_v <= id_max)) begin
            frame_v = {1'b0, id, FLAG_SELECT};
        end else begin
            frame_v = FRAME_IDLE;
        end
        return frame_v;
    endfunction

endpackage

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
// Two-flop synchroniser followed by a counting debounce FSM.
//   clk, rst         : clock, synchronous active-high reset
//   select_switches  : raw asynchronous switch inputs
//   debounced        : current candidate value (valid when stable=1)
//   commit_strobe    : high during the cycle whose closing edge commits
//                      the candidate (one cycle per debounce run)
//   stable           : registered, 1 once the candidate has been committed
// -----------------------------------------------------------------------------
module switch_debouncer
    import target_frame_pkg::*;
#(
    parameter int SW_WIDTH     = 5,
    parameter int DEBOUNCE_CNT = 5000000,
    parameter int CNT_WIDTH    = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] select_switches,
    output logic [SW_WIDTH-1:0] debounced,
    output logic                commit_strobe,
    output logic                stable
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CNT - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_TOP  = CNT_WIDTH'(DEBOUNCE_CNT);

    logic [SW_WIDTH-1:0]  sync_meta_r;
    logic [SW_WIDTH-1:0]  sync_q_r;
    logic [SW_WIDTH-1:0]  candidate_r;
    logic [CNT_WIDTH-1:0] count_r;
    db_state_e            state_r;
    logic                 stable_r;
    logic                 commit_s;

    // Commit fires on the edge where the counter steps onto DEBOUNCE_CNT,
    // so the strobe is decoded combinationally ahead of that edge.
    always_comb begin
        commit_s = 1'b0;
        if ((state_r == DB_COUNT) && (sync_q_r == candidate_r) && (count_r == CNT_LAST)) begin
            commit_s = 1'b1;
        end else begin
            commit_s = 1'b0;
        end
    end

    // Synchroniser, candidate tracking, stability counter and FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta_r <= '0;
            sync_q_r    <= '0;
            candidate_r <= '0;
            count_r     <= '0;
            state_r     <= DB_CAPTURE;
            stable_r    <= 1'b0;
        end else begin
            sync_meta_r <= select_switches;
            sync_q_r    <= sync_meta_r;
            if (sync_q_r != candidate_r) begin
                // Any movement restarts the debounce window.
                candidate_r <= sync_q_r;
                count_r     <= '0;
                stable_r    <= 1'b0;
                state_r     <= DB_COUNT;
            end else begin
                case (state_r)
                    DB_CAPTURE: begin
                        count_r <= '0;
                        state_r <= DB_COUNT;
                    end
                    DB_COUNT: begin
                        if (count_r == CNT_LAST) begin
                            count_r  <= CNT_TOP;
                            stable_r <= 1'b1;
                            state_r  <= DB_STABLE;
                        end else begin
                            count_r <= count_r + CNT_WIDTH'(1);
                        end
                    end
                    DB_STABLE: begin
                        state_r <= DB_STABLE;
                    end
                    default: begin
                        count_r  <= '0;
                        stable_r <= 1'b0;
                        state_r  <= DB_CAPTURE;
                    end
                endcase
            end
        end
    end

    assign debounced     = candidate_r;
    assign commit_strobe = commit_s;
    assign stable        = stable_r;

endmodule

// File: rtl/target_select_tx.sv
// -----------------------------------------------------------------------------
// target_select_tx
// Debounces the board selection switches, encodes the committed id into an
// 8-bit target frame and offers each new frame downstream over valid/ready.
//   clk, rst         : clock, synchronous active-high reset
//   select_switches  : raw switch inputs
//   resend           : one-cycle request to re-queue the held frame
//   tx_data/tx_valid : frame offered downstream, held until tx_ready
//   tx_ready         : downstream accept
//   data_out         : last committed frame (for status LEDs)
//   stable           : switches debounced and committed
//   overflow         : one-cycle pulse when the pending frame is overwritten
// -----------------------------------------------------------------------------
module target_select_tx
    import target_frame_pkg::*;
#(
    parameter int SW_WIDTH     = 5,
    parameter int ID_MIN       = 1,
    parameter int ID_MAX       = 20,
    parameter int DEBOUNCE_CNT = 5000000,
    parameter int CNT_WIDTH    = 23
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SW_WIDTH-1:0] select_switches,
    input  logic                resend,
    output logic [7:0]          tx_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic [7:0]          data_out,
    output logic                stable,
    output logic                overflow
);

    logic [SW_WIDTH-1:0] debounced_s;
    logic                commit_s;
    logic                stable_s;
    logic [4:0]          id_s;
    logic [FRAME_W-1:0]  enc_s;
    logic                queue_s;
    logic [FRAME_W-1:0]  frame_s;
    logic                accept_s;

    logic [FRAME_W-1:0]  data_out_r;
    logic [FRAME_W-1:0]  tx_data_r;
    logic                tx_valid_r;
    logic [FRAME_W-1:0]  pend_data_r;
    logic                pend_full_r;
    logic                overflow_r;

    switch_debouncer #(
        .SW_WIDTH    (SW_WIDTH),
        .DEBOUNCE_CNT(DEBOUNCE_CNT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_debouncer (
        .clk            (clk),
        .rst            (rst),
        .select_switches(select_switches),
        .debounced      (debounced_s),
        .commit_strobe  (commit_s),
        .stable         (stable_s)
    );

    assign id_s     = 5'(debounced_s);
    assign enc_s    = encode_frame(id_s, ID_MIN, ID_MAX);
    assign accept_s = tx_valid_r & tx_ready;

    // Choose what (if anything) gets queued this cycle. A commit edge always
    // has stable=0, so a coincident resend is absorbed by the commit.
    always_comb begin
        queue_s = 1'b0;
        frame_s = FRAME_IDLE;
        if (commit_s) begin
            if (enc_s != data_out_r) begin
                queue_s = 1'b1;
                frame_s = enc_s;
            end else begin
                queue_s = 1'b0;
                frame_s = FRAME_IDLE;
            end
        end else if (resend && stable_s) begin
            queue_s = 1'b1;
            frame_s = data_out_r;
        end else begin
            queue_s = 1'b0;
            frame_s = FRAME_IDLE;
        end
    end

    // Held copy of the last committed frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r <= FRAME_IDLE;
        end else if (commit_s && (enc_s != data_out_r)) begin
            data_out_r <= enc_s;
        end else begin
            data_out_r <= data_out_r;
        end
    end

    // Output register plus one pending slot; latest frame wins on overwrite.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_data_r   <= FRAME_IDLE;
            tx_valid_r  <= 1'b0;
            pend_data_r <= FRAME_IDLE;
            pend_full_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            overflow_r <= 1'b0;
            if (!tx_valid_r) begin
                if (queue_s) begin
                    tx_data_r  <= frame_s;
                    tx_valid_r <= 1'b1;
                end else begin
                    tx_valid_r <= 1'b0;
                end
            end else if (accept_s) begin
                if (pend_full_r) begin
                    tx_data_r  <= pend_data_r;
                    tx_valid_r <= 1'b1;
                    if (queue_s) begin
                        pend_data_r <= frame_s;
                    end else begin
                        pend_full_r <= 1'b0;
                    end
                end else if (queue_s) begin
                    tx_data_r  <= frame_s;
                    tx_valid_r <= 1'b1;
                end else begin
                    tx_valid_r <= 1'b0;
                end
            end else begin
                // Holding: tx_data must not move, so park the new frame.
                if (queue_s) begin
                    pend_data_r <= frame_s;
                    pend_full_r <= 1'b1;
                    overflow_r  <= pend_full_r;
                end else begin
                    pend_full_r <= pend_full_r;
                end
            end
        end
    end

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign data_out = data_out_r;
    assign stable   = stable_s;
    assign overflow = overflow_r;

endmodule
